inst_enc: RTL
=============

INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-006 fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-007 opcode  input  7  copied to inst[6:0].
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 funct3  input  3, funct7  input  7  function fields.
REQ-010 imm  input  32  full sign-extended immediate value to pack.
REQ-011 out_valid  output  1  inst holds a valid word.
REQ-012 out_ready  input  1  consumer takes the word when out_valid && out_ready.
REQ-013 inst  output  32  encoded RV32I instruction word.
REQ-014 range_err  output  1  one-cycle pulse for a rejected request.
REQ-015 enc_count  output  16  number of words enqueued, saturating.

Function
REQ-016 The block SHALL contain a 2-entry FIFO with states EMPTY, ONE, FULL; in_ready = !FULL, with no pass-through when FULL even if popping.
REQ-017 Latency SHALL be 1 cycle: a word accepted into EMPTY drives out_valid high on the following cycle.
REQ-018 Push and pop in the same cycle SHALL leave occupancy unchanged: ONE stays ONE; the head is replaced in order.
REQ-019 inst SHALL show the FIFO head; its value when out_valid=0 is don't-care.
REQ-020 Packing rules:
  - R: funct7 rs2 rs1 funct3 rd opcode.
  - I: imm[11:0] rs1 funct3 rd opcode.
  - S: imm[11:5] rs2 rs1 funct3 imm[4:0] opcode.
  - B: imm[12] imm[10:5] rs2 rs1 funct3 imm[4:1] imm[11] opcode.
  - U: imm[31:12] rd opcode.
  - J: imm[20] imm[10:1] imm[11] imm[19:12] rd opcode.
REQ-021 Range rules:
  - I and S: imm SHALL equal the sign-extension of imm[11:0].
  - B: imm[0]=0 and imm SHALL equal the sign-extension of imm[12:0].
  - J: imm[0]=0 and imm SHALL equal the sign-extension of imm[20:0].
  - U: imm[11:0]=0.
  - R: imm ignored.
REQ-022 An accepted request that fails REQ-021, or that has an illegal fmt, SHALL be consumed but not enqueued, and range_err SHALL pulse high for exactly the next cycle.
REQ-023 enc_count SHALL increment on each enqueue and saturate at 16'hFFFF; rejected requests SHALL not count.
REQ-024 A rejected request and a pop in the same cycle SHALL perform only the pop.

Reset
REQ-025 While rst_n=0, the FIFO SHALL be EMPTY; out_valid=0, range_err=0, enc_count=0; in_ready SHALL be 1 in the first cycle after deassertion.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words immediately, without waiting for a clock edge.

Verification
REQ-027 I, fmt=1, opcode=0010011, rd=1, rs1=0, funct3=0, imm=32'hFFFFFFFF, out_ready=1 -> next cycle out_valid=1, inst=32'hFFF00093, enc_count=1.
REQ-028 B, fmt=3, opcode=1100011, rs1=rs2=0, funct3=0, imm=32'hFFFFFFFC -> inst=32'hFE000EE3; the same with imm=32'h00000003 -> range_err pulses, out_valid stays 0, enc_count unchanged.
REQ-029 U, fmt=4, opcode=0110111, rd=0, imm=32'hF0000000 -> inst=32'hF0000037; imm=32'h00000800 with fmt=1 -> range_err pulse.
REQ-030 out_ready=0, three back-to-back valid requests -> in_ready drops after the second; with out_ready=1, words drain in order, one per cycle.
REQ-031 Assert rst_n=0 while FULL -> out_valid=0 and enc_count=0 immediately; after release, in_ready=1.

Source files
------------

// File: rtl/inst_enc.sv
// inst_enc: packs RV32I instruction fields into a 32-bit word behind a 2-entry output FIFO.
// Ports: clk/rst_n (async active-low); in_valid/in_ready request handshake with fmt, opcode,
// rd, rs1, rs2, funct3, funct7, imm fields; out_valid/out_ready/inst output handshake
// (inst = FIFO head); range_err pulses one cycle per rejected request; enc_count counts
// enqueued words, saturating.
module inst_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic        range_err,
  output logic [15:0] enc_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t      state_q;
  logic [31:0] head_q, tail_q, word_d;
  logic [15:0] cnt_q;
  logic        err_q, legal_d, acc, push, pop;
  always_comb begin
    word_d  = '0;
    legal_d = 1'b0;
    case (fmt)
      3'd0: begin
        word_d  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal_d = 1'b1;
      end
      3'd1: begin
        word_d  = {imm[11:0], rs1, funct3, rd, opcode};
        legal_d = imm == {{20{imm[11]}}, imm[11:0]};
      end
      3'd2: begin
        word_d  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal_d = imm == {{20{imm[11]}}, imm[11:0]};
      end
      3'd3: begin
        word_d  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal_d = !imm[0] && imm == {{19{imm[12]}}, imm[12:0]};
      end
      3'd4: begin
        word_d  = {imm[31:12], rd, opcode};
        legal_d = imm[11:0] == 12'd0;
      end
      3'd5: begin
        word_d  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal_d = !imm[0] && imm == {{11{imm[20]}}, imm[20:0]};
      end
      default: begin
        word_d  = '0;
        legal_d = 1'b0;
      end
    endcase
  end
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign inst      = head_q;
  assign range_err = err_q;
  assign enc_count = cnt_q;
  assign acc       = in_valid && in_ready;
  assign push      = acc && legal_d;
  assign pop       = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= acc && !legal_d;
      if (push && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      case (state_q)
        EMPTY: if (push) begin
          head_q  <= word_d;
          state_q <= ONE;
        end
        ONE: begin
          // simultaneous push and pop replaces the head and keeps occupancy at one
          if (push && pop) head_q <= word_d;
          else if (push) begin
            tail_q  <= word_d;
            state_q <= FULL;
          end else if (pop) state_q <= EMPTY;
        end
        default: if (pop) begin
          head_q  <= tail_q;
          state_q <= ONE;
        end
      endcase
    end
  end
endmodule
